barrido_teclado: RTL and testbench

BARRIDO_TECLADO -- requirements
Module: barrido_teclado

---
 rtl/barrido_pkg.sv | 57 +++++
 rtl/contador_estable.sv | 37 +++
 rtl/barrido_teclado.sv | 126 ++++++++++++
 tb/tb_barrido_teclado.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/barrido_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM states, row encodings and key lookup.
package barrido_pkg;

    typedef enum logic [1:0] {
        StScan,
        StDebPress,
        StHeld,
        StDebRel
    } estado_e;

    localparam logic [3:0] Fila0 = 4'b1000;
    localparam logic [3:0] Fila1 = 4'b0100;
    localparam logic [3:0] Fila2 = 4'b0010;
    localparam logic [3:0] Fila3 = 4'b0001;

    function automatic logic [3:0] siguiente_fila(input logic [3:0] fila);
        return {fila[0], fila[3:1]};
    endfunction

    // Position of a one-hot line counted from the MSB; rows and columns share the encoding.
    function automatic logic [1:0] indice(input logic [3:0] linea);
        logic [1:0] idx;
        case (linea)
            Fila0:   idx = 2'd0;
            Fila1:   idx = 2'd1;
            Fila2:   idx = 2'd2;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

    function automatic logic [3:0] codigo_tecla(input logic [3:0] fila, input logic [3:0] col);
        logic [3:0] pos;
        logic [3:0] cod;
        pos = {indice(fila), indice(col)};
        case (pos)
            4'd0:  cod = 4'h1;
            4'd1:  cod = 4'h2;
            4'd2:  cod = 4'h3;
            4'd3:  cod = 4'hA;
            4'd4:  cod = 4'h4;
            4'd5:  cod = 4'h5;
            4'd6:  cod = 4'h6;
            4'd7:  cod = 4'hB;
            4'd8:  cod = 4'h7;
            4'd9:  cod = 4'h8;
            4'd10: cod = 4'h9;
            4'd11: cod = 4'hC;
            4'd12: cod = 4'hE;
            4'd13: cod = 4'h0;
            4'd14: cod = 4'hF;
            4'd15: cod = 4'hD;
        endcase
        return cod;
    endfunction

endpackage

// File: rtl/contador_estable.sv
// Saturating count of consecutive matching samples; ultimo_o flags that one more match
// reaches MAX, so the owner can act on the same edge.
module contador_estable #(
    parameter int unsigned MAX = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic ultimo_o
);

    localparam int unsigned W = (MAX > 1) ? $clog2(MAX) : 1;
    localparam logic [W-1:0] Tope = W'(MAX - 1);

    logic [W-1:0] cuenta_q, cuenta_d;

    always_comb begin
        cuenta_d = cuenta_q;
        if (clr_i) begin
            cuenta_d = '0;
        end else if (en_i && (cuenta_q != Tope)) begin
            cuenta_d = cuenta_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cuenta_q <= '0;
        end else begin
            cuenta_q <= cuenta_d;
        end
    end

    assign ultimo_o = (cuenta_q == Tope);

endmodule

// File: rtl/barrido_teclado.sv
// 4x4 keypad scanner: rotates a one-hot row drive, debounces a single-column press and its
// release, and reports the accepted key code with a one-cycle pulse.
module barrido_teclado
    import barrido_pkg::*;
#(
    parameter int unsigned SCAN_TICKS      = 1000,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] columnas,
    output logic [3:0] filas,
    output logic [3:0] codigo,
    output logic       tecla_valida,
    output logic       presionada
);

    localparam int unsigned DwellW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam logic [DwellW-1:0] DwellLast = DwellW'(SCAN_TICKS - 1);

    estado_e           state_q, state_d;
    logic [3:0]        filas_q, filas_d;
    logic [3:0]        col_q, col_d;
    logic [3:0]        codigo_q, codigo_d;
    logic              pulso_q, pulso_d;
    logic [DwellW-1:0] dwell_q, dwell_d;

    logic pres_en, pres_ultimo, pres_hit;
    logic rel_en, rel_ultimo, rel_hit;

    assign pres_en  = (state_q == StDebPress) && (columnas == col_q);
    assign pres_hit = pres_en && pres_ultimo;
    assign rel_en   = (state_q == StDebRel) && (columnas == 4'b0000);
    assign rel_hit  = rel_en && rel_ultimo;

    // Any non-matching cycle (including being in another state) restarts the count.
    contador_estable #(
        .MAX(DEBOUNCE_CYCLES)
    ) u_deb_press (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .clr_i   (!pres_en || pres_ultimo),
        .en_i    (pres_en),
        .ultimo_o(pres_ultimo)
    );

    contador_estable #(
        .MAX(DEBOUNCE_CYCLES)
    ) u_deb_rel (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .clr_i   (!rel_en || rel_ultimo),
        .en_i    (rel_en),
        .ultimo_o(rel_ultimo)
    );

    always_comb begin
        state_d  = state_q;
        filas_d  = filas_q;
        col_d    = col_q;
        codigo_d = codigo_q;
        pulso_d  = 1'b0;
        dwell_d  = '0;
        case (state_q)
            StScan: begin
                dwell_d = dwell_q + DwellW'(1);
                if (dwell_q == DwellLast) begin
                    dwell_d = '0;
                    if ($onehot(columnas)) begin
                        col_d   = columnas;
                        state_d = StDebPress;
                    end else begin
                        filas_d = siguiente_fila(filas_q);
                    end
                end
            end
            StDebPress: begin
                if (columnas != col_q) begin
                    state_d = StScan;
                end else if (pres_hit) begin
                    state_d  = StHeld;
                    codigo_d = codigo_tecla(filas_q, col_q);
                    pulso_d  = 1'b1;
                end
            end
            StHeld: begin
                if (columnas != col_q) begin
                    state_d = StDebRel;
                end
            end
            StDebRel: begin
                if (rel_hit) begin
                    state_d = StScan;
                    filas_d = siguiente_fila(filas_q);
                end else if (columnas == col_q) begin
                    state_d = StHeld;
                end
            end
            default: state_d = StScan;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StScan;
            filas_q  <= Fila0;
            col_q    <= 4'b0000;
            codigo_q <= 4'b0000;
            pulso_q  <= 1'b0;
            dwell_q  <= '0;
        end else begin
            state_q  <= state_d;
            filas_q  <= filas_d;
            col_q    <= col_d;
            codigo_q <= codigo_d;
            pulso_q  <= pulso_d;
            dwell_q  <= dwell_d;
        end
    end

    assign filas        = filas_q;
    assign codigo       = codigo_q;
    assign tecla_valida = pulso_q;
    assign presionada   = (state_q == StHeld) || (state_q == StDebRel);

endmodule

// File: tb/tb_barrido_teclado.sv
// Bench for barrido_teclado: per-cycle comparison against a behavioural keypad model plus
// directed scenarios with hand-computed expectations.
module tb_barrido_teclado;

    localparam int ScanTicks = 4;
    localparam int Deb       = 3;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic [3:0] columnas = 4'b0000;
    logic [3:0] filas;
    logic [3:0] codigo;
    logic       tecla_valida;
    logic       presionada;

    barrido_teclado #(
        .SCAN_TICKS     (ScanTicks),
        .DEBOUNCE_CYCLES(Deb)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .columnas    (columnas),
        .filas       (filas),
        .codigo      (codigo),
        .tecla_valida(tecla_valida),
        .presionada  (presionada)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int pulses   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 scanning, 1 confirming press, 2 held, 3 confirming release.
    logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
    int         m_mode = 0;
    int         m_row  = 0;
    int         m_tick = 0;
    int         m_cnt  = 0;
    logic [3:0] m_col  = 4'b0000;
    logic [3:0] m_code = 4'b0000;
    bit         m_pulse = 1'b0;

    function automatic int msb_pos(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[3-i]) return i;
        end
        return 0;
    endfunction

    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            m_mode = 0; m_row = 0; m_tick = 0; m_cnt = 0;
            m_col = 4'b0000; m_code = 4'b0000; m_pulse = 1'b0;
        end else begin
            m_pulse = 1'b0;
            case (m_mode)
                0: begin
                    if (m_tick == ScanTicks - 1) begin
                        m_tick = 0;
                        if ($countones(columnas) == 1) begin
                            m_col = columnas; m_cnt = 0; m_mode = 1;
                        end else begin
                            m_row = (m_row + 1) % 4;
                        end
                    end else begin
                        m_tick++;
                    end
                end
                1: begin
                    if (columnas == m_col) begin
                        m_cnt++;
                        if (m_cnt == Deb) begin
                            m_mode = 2;
                            m_code = keymap[m_row * 4 + msb_pos(m_col)];
                            m_pulse = 1'b1;
                        end
                    end else begin
                        m_mode = 0; m_tick = 0;
                    end
                end
                2: begin
                    if (columnas != m_col) begin
                        m_mode = 3; m_cnt = 0;
                    end
                end
                default: begin
                    if (columnas == 4'b0000) begin
                        m_cnt++;
                        if (m_cnt == Deb) begin
                            m_mode = 0; m_tick = 0; m_row = (m_row + 1) % 4;
                        end
                    end else if (columnas == m_col) begin
                        m_mode = 2;
                    end else begin
                        m_cnt = 0;
                    end
                end
            endcase
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("filas", filas, 4'b1000 >> m_row);
            check("codigo", codigo, m_code);
            check("tecla_valida", tecla_valida, m_pulse);
            check("presionada", presionada, (m_mode >= 2) ? 1 : 0);
            if (tecla_valida === 1'b1) pulses++;
        end
    end

    task automatic wait_row(input logic [3:0] target);
        int n = 0;
        while (filas === target && n < 40) begin @(negedge clk); n++; end
        while (filas !== target && n < 40) begin @(negedge clk); n++; end
        check("wait_row", filas, target);
    endtask

    task automatic press_timed(input logic [3:0] col, output int when);
        when = -1;
        columnas = col;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (tecla_valida === 1'b1 && when < 0) when = k;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] seqf [20];
        int when;
        int p0;

        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("reset filas", filas, 4'b1000);
        check("reset codigo", codigo, 4'h0);
        check("reset presionada", presionada, 1'b0);

        // Idle scan: each row held four cycles.
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            seqf[i] = filas;
        end
        check("idle row0 end", seqf[2], 4'b1000);
        check("idle row1 start", seqf[3], 4'b0100);
        check("idle row1 end", seqf[6], 4'b0100);
        check("idle row2 start", seqf[7], 4'b0010);
        check("idle row3 start", seqf[11], 4'b0001);
        check("idle wrap", seqf[15], 4'b1000);
        check("idle pulses", pulses, 0);

        // Key 8: row 0010, column 0100.
        wait_row(4'b0010);
        p0 = pulses;
        press_timed(4'b0100, when);
        check("key8 latency", when, 7);
        check("key8 codigo", codigo, 4'h8);
        check("key8 presionada", presionada, 1'b1);
        check("key8 filas frozen", filas, 4'b0010);
        check("key8 one pulse", pulses - p0, 1);
        columnas = 4'b0000;
        repeat (3) @(negedge clk);
        check("key8 release pending", presionada, 1'b1);
        @(negedge clk);
        check("key8 released", presionada, 1'b0);
        check("key8 next row", filas, 4'b0001);

        // Key D: row 0001, column 0001, then release wraps to row 1000.
        p0 = pulses;
        press_timed(4'b0001, when);
        check("keyD latency", when, 7);
        check("keyD codigo", codigo, 4'hD);
        columnas = 4'b0000;
        repeat (4) @(negedge clk);
        check("keyD released", presionada, 1'b0);
        check("keyD wrap", filas, 4'b1000);
        check("keyD one pulse", pulses - p0, 1);

        // Bounce: two matching cycles in press debounce, then open.
        p0 = pulses;
        columnas = 4'b1000;
        repeat (6) @(negedge clk);
        columnas = 4'b0000;
        @(negedge clk);
        check("bounce back to scan", presionada, 1'b0);
        repeat (3) @(negedge clk);
        check("bounce row rescanned", filas, 4'b1000);
        @(negedge clk);
        check("bounce row advances", filas, 4'b0100);
        check("bounce no pulse", pulses - p0, 0);
        check("bounce codigo kept", codigo, 4'hD);

        // Two columns at a sample are ignored.
        columnas = 4'b0110;
        repeat (4) @(negedge clk);
        check("multi advances", filas, 4'b0010);
        check("multi no pulse", pulses - p0, 0);

        // Key 3, then a short release glitch, then reset while held.
        columnas = 4'b0000;
        wait_row(4'b1000);
        p0 = pulses;
        press_timed(4'b0010, when);
        check("key3 latency", when, 7);
        check("key3 codigo", codigo, 4'h3);
        columnas = 4'b0000;
        repeat (2) @(negedge clk);
        columnas = 4'b0010;
        repeat (6) @(negedge clk);
        check("glitch still held", presionada, 1'b1);
        check("glitch one pulse", pulses - p0, 1);
        check("glitch filas", filas, 4'b1000);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset filas", filas, 4'b1000);
        check("midreset codigo", codigo, 4'h0);
        check("midreset pulse", tecla_valida, 1'b0);
        check("midreset presionada", presionada, 1'b0);
        rst_n = 1'b1;
        columnas = 4'b0000;
        repeat (3) @(negedge clk);
        check("restart row0", filas, 4'b1000);
        @(negedge clk);
        check("restart row1", filas, 4'b0100);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
